// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP32 add/sub datapath.
// The operand classes and the unpacked operand record are defined here.
package fpu_pkg;

    typedef enum logic [2:0] {
        ZERO    = 3'd0,
        SUBNORM = 3'd1,
        NORMAL  = 3'd2,
        INF     = 3'd3,
        QNAN    = 3'd4,
        SNAN    = 3'd5
    } fp_class_t;

    localparam logic [31:0] POS_INF  = 32'h7F80_0000;
    localparam logic [31:0] NEG_INF  = 32'hFF80_0000;
    localparam logic [31:0] POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] NEG_ZERO = 32'h8000_0000;
    localparam logic [31:0] CAN_NAN  = 32'h7FC0_0000;
    localparam int          EXP_MAX  = 255;
    localparam int          MANT_W   = 23;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        op;
        fp_class_t   class_a;
        fp_class_t   class_b;
        logic        exc;
        logic        sign_big;
        logic        eff_sub;
        logic [23:0] mant_big;
        logic [23:0] mant_small;
        logic [7:0]  exp_big;
        logic [4:0]  align_shift;
        logic        swap;
    } unpack_rec_t;

endpackage

// File: rtl/fp_classify.sv
// Per-operand classification: IEEE-754 class, effective exponent and
// 24-bit mantissa with hidden bit. Sign is handled by the caller.
module fp_classify
    import fpu_pkg::*;
(
    input  logic [30:0] mag,
    output fp_class_t   cls,
    output logic [7:0]  eff_exp,
    output logic [23:0] mant
);

    logic [7:0]        e;
    logic [MANT_W-1:0] f;

    assign e = mag[30:23];
    assign f = mag[MANT_W-1:0];

    always_comb begin
        cls = NORMAL;
        if (e == 8'd0) begin
            cls = (f == '0) ? ZERO : SUBNORM;
        end else if (e == 8'(EXP_MAX)) begin
            if (f == '0)
                cls = INF;
            else
                cls = f[MANT_W-1] ? QNAN : SNAN;
        end
    end

    // Subnormals share the minimum normal exponent; only normals carry the hidden one.
    assign eff_exp = (cls == SUBNORM) ? 8'd1 : e;
    assign mant    = {(cls == NORMAL), f};

endmodule

// File: rtl/fpu_operand_unpack.sv
// FP32 add/sub input stage: classifies both operands, orders them by
// magnitude and presents one registered record per accepted pair.
module fpu_operand_unpack
    import fpu_pkg::*;
#(
    parameter bit SKID_EN   = 1'b1,
    parameter int SHIFT_SAT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        operation_select,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic        out_op,
    output logic [2:0]  class_a,
    output logic [2:0]  class_b,
    output logic        exception,
    output logic        sign_big,
    output logic        eff_sub,
    output logic [23:0] mant_big,
    output logic [23:0] mant_small,
    output logic [7:0]  exp_big,
    output logic [4:0]  align_shift,
    output logic        swap
);

    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} skid_state_t;

    localparam logic [7:0] SAT8 = 8'(SHIFT_SAT);

    function automatic logic [4:0] sat_shift(input logic [7:0] d);
        return (d > SAT8) ? SAT8[4:0] : d[4:0];
    endfunction

    function automatic logic is_exc(input fp_class_t c);
        return (c != NORMAL) && (c != SUBNORM);
    endfunction

    fp_class_t   cls_a_p0, cls_b_p0;
    logic [7:0]  exp_a_p0, exp_b_p0, exp_small_p0;
    logic [23:0] mant_a_p0, mant_b_p0;
    unpack_rec_t rec_p0, rec_p1, skid_p1;
    skid_state_t state_q, state_d;
    logic        accept, pop, ld_new, ld_from_skid, ld_skid;

    fp_classify u_cls_a (.mag(a[30:0]), .cls(cls_a_p0), .eff_exp(exp_a_p0), .mant(mant_a_p0));
    fp_classify u_cls_b (.mag(b[30:0]), .cls(cls_b_p0), .eff_exp(exp_b_p0), .mant(mant_b_p0));

    // Stage p0: combinational record from the raw operands.
    always_comb begin
        rec_p0             = '0;
        rec_p0.a           = a;
        rec_p0.b           = b;
        rec_p0.op          = operation_select;
        rec_p0.class_a     = cls_a_p0;
        rec_p0.class_b     = cls_b_p0;
        rec_p0.exc         = is_exc(cls_a_p0) || is_exc(cls_b_p0);
        rec_p0.eff_sub     = a[31] ^ b[31] ^ operation_select;
        rec_p0.swap        = (b[30:0] > a[30:0]);
        rec_p0.sign_big    = rec_p0.swap ? (b[31] ^ operation_select) : a[31];
        rec_p0.exp_big     = rec_p0.swap ? exp_b_p0 : exp_a_p0;
        exp_small_p0       = rec_p0.swap ? exp_a_p0 : exp_b_p0;
        rec_p0.mant_big    = rec_p0.swap ? mant_b_p0 : mant_a_p0;
        rec_p0.mant_small  = rec_p0.swap ? mant_a_p0 : mant_b_p0;
        rec_p0.align_shift = sat_shift(rec_p0.exp_big - exp_small_p0);
    end

    assign out_valid = (state_q != S_EMPTY);
    // With the skid entry, in_ready depends only on registered state.
    assign in_ready  = SKID_EN ? (state_q != S_TWO) : ((state_q == S_EMPTY) || out_ready);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_d      = state_q;
        ld_new       = 1'b0;
        ld_from_skid = 1'b0;
        ld_skid      = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (accept) begin
                    ld_new  = 1'b1;
                    state_d = S_ONE;
                end
            end
            S_ONE: begin
                if (accept && pop) begin
                    ld_new = 1'b1;
                end else if (accept) begin
                    ld_skid = 1'b1;
                    state_d = S_TWO;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end
            S_TWO: begin
                if (pop) begin
                    ld_from_skid = 1'b1;
                    state_d      = S_ONE;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= S_EMPTY;
        else
            state_q <= state_d;
    end

    // Stage p1: output register plus skid entry holding the second record.
    always_ff @(posedge clk) begin
        if (rst) begin
            rec_p1  <= '0;
            skid_p1 <= '0;
        end else begin
            if (ld_new)
                rec_p1 <= rec_p0;
            else if (ld_from_skid)
                rec_p1 <= skid_p1;
            if (ld_skid)
                skid_p1 <= rec_p0;
        end
    end

    assign out_a       = rec_p1.a;
    assign out_b       = rec_p1.b;
    assign out_op      = rec_p1.op;
    assign class_a     = rec_p1.class_a;
    assign class_b     = rec_p1.class_b;
    assign exception   = rec_p1.exc;
    assign sign_big    = rec_p1.sign_big;
    assign eff_sub     = rec_p1.eff_sub;
    assign mant_big    = rec_p1.mant_big;
    assign mant_small  = rec_p1.mant_small;
    assign exp_big     = rec_p1.exp_big;
    assign align_shift = rec_p1.align_shift;
    assign swap        = rec_p1.swap;

endmodule
